legv8_bus_controller: RTL and testbench
=======================================

LEGV8_BUS_CONTROLLER -- requirements
Module: legv8_bus_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameters RAM_BASE and ROM_BASE, defaults 32'h80000000 and 32'h60000000, region base addresses.
REQ-004 SHALL have parameters RAM_AWIDTH and ROM_AWIDTH, default 14 each, region size in address bits (region = base .. base+2^AWIDTH-1).
REQ-005 SHALL have parameter WAIT_CYCLES, default 1, range 0-15, memory wait states.
REQ-006 Ports (name, direction, width, meaning):
- clock  in  1  single clock, rising edge; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high.
- req  in  1  control word valid this cycle.
- AS  in  1  address source: 0 ALU, 1 PC.
- DS  in  2  data source: 00 ALU, 01 B, 10 PC, 11 memory.
- MW  in  1  memory write.
- size  in  2  00 byte, 01 half, 10 word, 11 dword.
- address  in  ADDR_WIDTH  current address bus value.
- addr_en  out  2  one-hot address-bus tristate enables.
- data_en  out  4  one-hot data-bus tristate enables.
- ram_cs, rom_cs  out  1 each  region chip selects.
- mem_we  out  1  memory write strobe.
- ready  out  1  control word complete; 0 = stall.
- fault  out  1  access error, valid only when ready=1.

Function
REQ-007 FSM states SHALL be IDLE, WAIT, DONE.
REQ-008 In IDLE with req=1 and non-memory word (DS!=11, MW=0): data_en=one-hot(DS), addr_en=one-hot(AS), ready=1 the same cycle, stay IDLE.
REQ-009 In IDLE with req=1 and memory word (DS=11 or MW=1): latch AS, DS, MW, size, address; ready=0; go to WAIT if WAIT_CYCLES>0, else DONE.
REQ-010 WAIT SHALL last exactly WAIT_CYCLES cycles (down-counter loaded with WAIT_CYCLES-1); ready=0; then DONE.
REQ-011 DONE SHALL last one cycle: ready=1; next state IDLE; total latency = WAIT_CYCLES+1 cycles after acceptance.
REQ-012 During WAIT/DONE, addr_en=one-hot(latched AS); chip select of the decoded region held high.
REQ-013 Reads (DS=11, MW=0): data_en=0000 in acceptance/WAIT cycles, data_en=1000 in DONE only.
REQ-014 Writes (MW=1, DS!=11): data_en=one-hot(latched DS) for whole access; mem_we=1 in DONE only, for exactly one cycle.
REQ-015 Unmapped address: no cs, no mem_we, data_en=0000, fault=1 in DONE.
REQ-016 Write to ROM region: rom_cs=1, mem_we=0, fault=1 in DONE.
REQ-017 DS=11 with MW=1: illegal; no cs, no mem_we, data_en=0000, fault=1 in DONE.
REQ-018 req=0 in IDLE: addr_en=00, data_en=0000, cs=0, ready=0, fault=0.
REQ-019 Inputs during WAIT/DONE SHALL be ignored; access completes from latched values even if req drops.
REQ-020 RAM and ROM decode SHALL never both be high; if regions overlap, RAM wins.

Reset
REQ-021 reset=1 SHALL asynchronously force IDLE, counter 0, and all outputs 0.
REQ-022 reset asserted mid-access SHALL abort it with no mem_we pulse; the first cycle after release behaves as IDLE.

Configuration
REQ-023 Macro MISALIGN_CHECK_EN defined: address not aligned to size (half: bit0; word: bits1:0; dword: bits2:0 nonzero) → no cs, no mem_we, data_en=0000, fault=1 in DONE, same latency.
REQ-024 Macro MISALIGN_CHECK_EN undefined: alignment not checked; misaligned accesses proceed normally.

Verification
REQ-025 req=1, DS=00, AS=0 → same cycle data_en=0001, addr_en=01, ready=1.
REQ-026 WAIT_CYCLES=1, read at 32'h80000010, size=11 → ready low 2 cycles, ram_cs high 3 cycles, DONE: data_en=1000, ready=1, fault=0.
REQ-027 WAIT_CYCLES=0, write at 32'h80000008, DS=01 → DONE next cycle, mem_we one-cycle pulse, data_en=0010 for both cycles.
REQ-028 Write at 32'h60000000 → rom_cs=1, mem_we=0, fault=1; read at 32'h00001000 → no cs, fault=1.
REQ-029 WAIT_CYCLES=3, reset asserted in second WAIT cycle → all outputs 0 immediately, no mem_we; following req serviced normally.
REQ-030 MISALIGN_CHECK_EN defined, word read at 32'h80000002 → fault=1, ram_cs=0; undefined → fault=0, data_en=1000.

Source files
------------

// File: rtl/legv8_bus_controller.sv
// legv8_bus_controller: sequences LEGv8 datapath bus enables and memory accesses with wait states.
// Optional alignment fault checking is compiled in with `define MISALIGN_CHECK_EN.
module legv8_bus_controller #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE    = 32'h80000000,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE    = 32'h60000000,
    parameter int                    RAM_AWIDTH  = 14,
    parameter int                    ROM_AWIDTH  = 14,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  AS,
    input  logic [1:0]            DS,
    input  logic                  MW,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [1:0]            addr_en,
    output logic [3:0]            data_en,
    output logic                  ram_cs,
    output logic                  rom_cs,
    output logic                  mem_we,
    output logic                  ready,
    output logic                  fault
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

`ifdef MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif
    localparam state_t     FIRST    = (WAIT_CYCLES > 0) ? WAIT : DONE;
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || DATA_WIDTH < 64 || DATA_WIDTH % 8 != 0) begin : g_param_check
        $error("legv8_bus_controller: WAIT_CYCLES must be 0-15 and DATA_WIDTH a byte multiple of at least 64");
    end

    state_t                  state, state_nx;
    logic [3:0]              cnt;
    logic                    as_q, mw_q;
    logic [1:0]              ds_q, size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    c_as, c_mw;
    logic [1:0]              c_ds, c_size;
    logic [ADDR_WIDTH-1:0]   c_addr, ram_off, rom_off;
    logic [3:0]              ds_hot;
    logic                    act, mem, accept, illegal, mis_raw, misalign, no_cs;
    logic                    ram_hit, rom_hit, unmapped, bad, done;

    // The acceptance cycle works from live inputs; later cycles use the latched word.
    assign c_as   = (state == IDLE) ? AS : as_q;
    assign c_ds   = (state == IDLE) ? DS : ds_q;
    assign c_mw   = (state == IDLE) ? MW : mw_q;
    assign c_size = (state == IDLE) ? size : size_q;
    assign c_addr = (state == IDLE) ? address : addr_q;

    assign ram_off  = c_addr - RAM_BASE;
    assign rom_off  = c_addr - ROM_BASE;
    assign ram_hit  = (ram_off >> RAM_AWIDTH) == '0;
    assign rom_hit  = ((rom_off >> ROM_AWIDTH) == '0) && !ram_hit;
    assign unmapped = !(ram_hit || rom_hit);

    assign mis_raw  = (c_size == 2'b01 && c_addr[0]) ||
                      (c_size == 2'b10 && |c_addr[1:0]) ||
                      (c_size == 2'b11 && |c_addr[2:0]);
    assign misalign = MISALIGN_EN && mis_raw;

    assign act     = !reset && (state != IDLE || req);
    assign mem     = (c_ds == 2'b11) || c_mw;
    assign accept  = (state == IDLE) && req && mem;
    assign illegal = (c_ds == 2'b11) && c_mw;
    assign no_cs   = illegal || misalign;
    assign bad     = no_cs || unmapped || (c_mw && rom_hit);
    assign done    = !reset && (state == DONE);
    assign ds_hot  = 4'b0001 << c_ds;

    // State register, wait counter and control-word latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            as_q   <= 1'b0;
            ds_q   <= '0;
            mw_q   <= 1'b0;
            size_q <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt    <= CNT_INIT;
                as_q   <= AS;
                ds_q   <= DS;
                mw_q   <= MW;
                size_q <= size;
                addr_q <= address;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next state and bus/memory control outputs.
    always_comb begin
        state_nx = (state == IDLE) ? (accept ? FIRST : IDLE) :
                   (state == WAIT) ? ((cnt == '0) ? DONE : WAIT) : IDLE;
        addr_en  = '0;
        data_en  = '0;
        ram_cs   = 1'b0;
        rom_cs   = 1'b0;
        mem_we   = 1'b0;
        ready    = 1'b0;
        fault    = 1'b0;
        if (act) begin
            addr_en = c_as ? 2'b10 : 2'b01;
            data_en = !mem ? ds_hot :
                      (no_cs || unmapped) ? 4'b0000 :
                      (c_ds == 2'b11) ? (done ? 4'b1000 : 4'b0000) : ds_hot;
            ram_cs  = mem && !no_cs && ram_hit;
            rom_cs  = mem && !no_cs && rom_hit;
            mem_we  = done && c_mw && !no_cs && ram_hit;
            ready   = !mem || done;
            fault   = done && bad;
        end
    end
endmodule

// File: tb/tb_legv8_bus_controller.sv
// tb_legv8_bus_controller: directed and randomized checks of legv8_bus_controller at WAIT_CYCLES 1, 0 and 3.
module tb_legv8_bus_controller;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    localparam int WV [3] = '{1, 0, 3};

    logic        clock, reset, req, as_s, mw_s;
    logic [1:0]  ds_s, size_s;
    logic [31:0] address;
    logic [1:0]  addr_en [3];
    logic [3:0]  data_en [3];
    logic        ram_cs [3], rom_cs [3], mem_we [3], ready [3], fault [3];
    int          errors = 0;
    int          checks = 0;

    legv8_bus_controller #(.WAIT_CYCLES(1)) u_w1 (
        .clock(clock), .reset(reset), .req(req), .AS(as_s), .DS(ds_s), .MW(mw_s), .size(size_s),
        .address(address), .addr_en(addr_en[0]), .data_en(data_en[0]), .ram_cs(ram_cs[0]),
        .rom_cs(rom_cs[0]), .mem_we(mem_we[0]), .ready(ready[0]), .fault(fault[0]));
    legv8_bus_controller #(.WAIT_CYCLES(0)) u_w0 (
        .clock(clock), .reset(reset), .req(req), .AS(as_s), .DS(ds_s), .MW(mw_s), .size(size_s),
        .address(address), .addr_en(addr_en[1]), .data_en(data_en[1]), .ram_cs(ram_cs[1]),
        .rom_cs(rom_cs[1]), .mem_we(mem_we[1]), .ready(ready[1]), .fault(fault[1]));
    legv8_bus_controller #(.WAIT_CYCLES(3)) u_w3 (
        .clock(clock), .reset(reset), .req(req), .AS(as_s), .DS(ds_s), .MW(mw_s), .size(size_s),
        .address(address), .addr_en(addr_en[2]), .data_en(data_en[2]), .ram_cs(ram_cs[2]),
        .rom_cs(rom_cs[2]), .mem_we(mem_we[2]), .ready(ready[2]), .fault(fault[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view: addr_en(2) data_en(4) ram_cs rom_cs mem_we ready fault
    function automatic logic [10:0] o(input int i);
        return {addr_en[i], data_en[i], ram_cs[i], rom_cs[i], mem_we[i], ready[i], fault[i]};
    endfunction

    task automatic step;
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic r, input logic a, input logic [1:0] d, input logic m,
                         input logic [1:0] s, input logic [31:0] ad);
        req = r; as_s = a; ds_s = d; mw_s = m; size_s = s; address = ad;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        step;
        step;
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] rnd_addr;
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0: a = 32'h80000000 + $urandom_range(0, 16383);
            1: a = 32'h60000000 + $urandom_range(0, 16383);
            2: a = 32'h80004000;
            3: a = 32'h7fffffff;
            4: a = 32'h60003fff;
            default: a = $urandom;
        endcase
        if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
        return a;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        drive(1, 1, 2'd2, 0, 2'd0, 32'h0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o(i) !== 11'b0) begin errors++; $display("FAIL reset_hold[%0d]: got %b exp %b", i, o(i), 11'b0); end
        end
        step;
        reset = 1'b0;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o(i) !== 11'b0) begin errors++; $display("FAIL reset_idle[%0d]: got %b exp %b", i, o(i), 11'b0); end
        end
    endtask

    task automatic test_nonmem;
        logic [10:0] e;
        do_reset;
        drive(1, 0, 2'd0, 0, 2'd0, 32'h0);
        #1;
        e = 11'b01_0001_0_0_0_1_0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o(i) !== e) begin errors++; $display("FAIL nonmem_alu[%0d]: got %b exp %b", i, o(i), e); end
        end
        step;
        drive(1, 1, 2'd2, 0, 2'd0, 32'h80000000);
        #1;
        e = 11'b10_0100_0_0_0_1_0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o(i) !== e) begin errors++; $display("FAIL nonmem_pc[%0d]: got %b exp %b", i, o(i), e); end
        end
    endtask

    task automatic test_read_w1;
        logic [10:0] e;
        do_reset;
        drive(1, 0, 2'd3, 0, 2'd3, 32'h80000010);
        #1;
        e = 11'b01_0000_1_0_0_0_0;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL read_accept: got %b exp %b", o(0), e); end
        step;
        drive(1, 1, 2'd0, 0, 2'd0, 32'h00000000);
        #1;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL read_wait: got %b exp %b", o(0), e); end
        step;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        #1;
        e = 11'b01_1000_1_0_0_1_0;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL read_done: got %b exp %b", o(0), e); end
        step;
        #1;
        checks++;
        if (o(0) !== 11'b0) begin errors++; $display("FAIL read_after: got %b exp %b", o(0), 11'b0); end
    endtask

    task automatic test_write_w0;
        logic [10:0] e;
        do_reset;
        drive(1, 0, 2'd1, 1, 2'd3, 32'h80000008);
        #1;
        e = 11'b01_0010_1_0_0_0_0;
        checks++;
        if (o(1) !== e) begin errors++; $display("FAIL write_accept: got %b exp %b", o(1), e); end
        step;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        #1;
        e = 11'b01_0010_1_0_1_1_0;
        checks++;
        if (o(1) !== e) begin errors++; $display("FAIL write_done: got %b exp %b", o(1), e); end
        step;
        #1;
        checks++;
        if (o(1) !== 11'b0) begin errors++; $display("FAIL write_after: got %b exp %b", o(1), 11'b0); end
    endtask

    task automatic test_rom_unmapped;
        logic [10:0] e;
        do_reset;
        drive(1, 0, 2'd0, 1, 2'd3, 32'h60000000);
        #1;
        e = 11'b01_0001_0_1_0_0_0;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL romwr_accept: got %b exp %b", o(0), e); end
        step;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        step;
        #1;
        e = 11'b01_0001_0_1_0_1_1;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL romwr_done: got %b exp %b", o(0), e); end
        step;
        drive(1, 0, 2'd3, 0, 2'd3, 32'h00001000);
        #1;
        e = 11'b01_0000_0_0_0_0_0;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL unmap_accept: got %b exp %b", o(0), e); end
        step;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        step;
        #1;
        e = 11'b01_0000_0_0_0_1_1;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL unmap_done: got %b exp %b", o(0), e); end
    endtask

    task automatic test_reset_midaccess;
        logic [10:0] e;
        int n;
        do_reset;
        drive(1, 0, 2'd1, 1, 2'd3, 32'h80000020);
        step;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        step;
        #1;
        e = 11'b01_0010_1_0_0_0_0;
        checks++;
        if (o(2) !== e) begin errors++; $display("FAIL mid_wait2: got %b exp %b", o(2), e); end
        reset = 1'b1;
        #1;
        checks++;
        if (o(2) !== 11'b0) begin errors++; $display("FAIL mid_reset_now: got %b exp %b", o(2), 11'b0); end
        step;
        #1;
        checks++;
        if (o(2) !== 11'b0) begin errors++; $display("FAIL mid_reset_hold: got %b exp %b", o(2), 11'b0); end
        reset = 1'b0;
        drive(1, 0, 2'd0, 0, 2'd0, 32'h0);
        #1;
        e = 11'b01_0001_0_0_0_1_0;
        checks++;
        if (o(2) !== e) begin errors++; $display("FAIL mid_release_idle: got %b exp %b", o(2), e); end
        step;
        drive(1, 0, 2'd3, 0, 2'd3, 32'h80000040);
        n = 0;
        #1;
        while (ready[2] !== 1'b1 && n < 10) begin
            checks++;
            if (mem_we[2] !== 1'b0) begin errors++; $display("FAIL mid_no_we: got %b exp 0", mem_we[2]); end
            step;
            drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
            n++;
            #1;
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL mid_next_latency: got %0d cycles exp 4", n); end
        e = 11'b01_1000_1_0_0_1_0;
        checks++;
        if (o(2) !== e) begin errors++; $display("FAIL mid_next_done: got %b exp %b", o(2), e); end
    endtask

    task automatic test_misalign;
        logic [10:0] e;
        do_reset;
        drive(1, 0, 2'd3, 0, 2'd2, 32'h80000002);
        #1;
        e = MIS ? 11'b01_0000_0_0_0_0_0 : 11'b01_0000_1_0_0_0_0;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL mis_accept: got %b exp %b", o(0), e); end
        step;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        step;
        #1;
        e = MIS ? 11'b01_0000_0_0_0_1_1 : 11'b01_1000_1_0_0_1_0;
        checks++;
        if (o(0) !== e) begin errors++; $display("FAIL mis_done: got %b exp %b", o(0), e); end
    endtask

    task automatic test_random;
        bit          busy [3];
        int          pos [3];
        logic        t_as [3], t_mw [3];
        logic [1:0]  t_ds [3], t_sz [3];
        logic [31:0] t_a [3];
        logic        ea, em, ram, rom, act, mem, ill, mis, done, no_cs, unm;
        logic [1:0]  ed, es;
        logic [31:0] a;
        logic [10:0] e;
        do_reset;
        for (int i = 0; i < 3; i++) busy[i] = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 6, 1'($urandom), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), rnd_addr());
            #1;
            for (int i = 0; i < 3; i++) begin
                {ea, ed, em, es, a} = busy[i] ? {t_as[i], t_ds[i], t_mw[i], t_sz[i], t_a[i]}
                                              : {as_s, ds_s, mw_s, size_s, address};
                act   = !reset && (busy[i] || req);
                mem   = (ed == 2'd3) || em;
                ill   = (ed == 2'd3) && em;
                mis   = MIS && (a % (32'd1 << es)) != 0;
                ram   = a >= 32'h80000000 && a <= 32'h80003fff;
                rom   = a >= 32'h60000000 && a <= 32'h60003fff && !ram;
                unm   = !ram && !rom;
                no_cs = ill || mis;
                done  = !reset && busy[i] && pos[i] == WV[i] + 1;
                e = '0;
                if (act) begin
                    e[10:9] = ea ? 2'b10 : 2'b01;
                    e[8:5]  = !mem ? 4'(1 << ed) : (no_cs || unm) ? 4'b0 :
                              (ed == 2'd3) ? (done ? 4'b1000 : 4'b0) : 4'(1 << ed);
                    e[4]    = mem && !no_cs && ram;
                    e[3]    = mem && !no_cs && rom;
                    e[2]    = done && em && !no_cs && ram;
                    e[1]    = !mem || done;
                    e[0]    = done && (no_cs || unm || (em && rom));
                end
                checks++;
                if (o(i) !== e) begin
                    errors++;
                    $display("FAIL random[w=%0d] cycle %0d: got %b exp %b", WV[i], c, o(i), e);
                end
                if (reset) busy[i] = 1'b0;
                else if (busy[i]) begin
                    if (done) busy[i] = 1'b0;
                    else pos[i]++;
                end else if (req && mem) begin
                    busy[i] = 1'b1;
                    pos[i]  = 1;
                    {t_as[i], t_ds[i], t_mw[i], t_sz[i], t_a[i]} = {as_s, ds_s, mw_s, size_s, address};
                end
            end
            step;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0);
        #3;
        test_reset;
        test_nonmem;
        test_read_w1;
        test_write_w0;
        test_rom_unmapped;
        test_reset_midaccess;
        test_misalign;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
